// File: rtl/hex_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module : hex_disp_pkg
//  Brief  : Scan-mode encodings and segment constants shared by the hex display
//  Rev    : 1.0  initial release
// ============================================================================
package hex_disp_pkg;

  typedef enum logic [1:0] {
    MODE_STEP   = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_DIRECT = 2'b11
  } scan_mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/seg7.sv
`default_nettype none
// ============================================================================
//  Module : seg7
//  Brief  : Hex nibble to active-low 7-segment decoder, leds[0]=a .. leds[6]=g
//  Rev    : 1.0  initial release
// ============================================================================
module seg7
  import hex_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] leds
);

  always_comb begin
    leds = SEG_BLANK;
    case (bcd)
      4'h0: leds = 7'h40;
      4'h1: leds = 7'h79;
      4'h2: leds = 7'h24;
      4'h3: leds = 7'h30;
      4'h4: leds = 7'h19;
      4'h5: leds = 7'h12;
      4'h6: leds = 7'h02;
      4'h7: leds = 7'h78;
      4'h8: leds = 7'h00;
      4'h9: leds = 7'h10;
      4'hA: leds = 7'h08;
      4'hB: leds = 7'h03;
      4'hC: leds = 7'h46;
      4'hD: leds = 7'h21;
      4'hE: leds = 7'h06;
      4'hF: leds = 7'h0E;
      default: leds = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hex_word_scanner.sv
`default_nettype none
// ============================================================================
//  Module : hex_word_scanner
//  Brief  : Captures a debug word and scans its nibbles across NUM_WIN digits
//           plus an index digit (step / auto-scroll / hold / direct modes)
//  Rev    : 1.0  initial release
// ============================================================================
module hex_word_scanner
  import hex_disp_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_WIN = 2,
  parameter int DWELL   = 2**27
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      char,
  input  logic                   char_valid,
  input  logic [1:0]             mode,
  input  logic [3:0]             sel_idx,
  input  logic                   blank,
  output logic [7*NUM_WIN-1:0]   disp_data,
  output logic [6:0]             disp_idx,
  output logic                   led_valid,
  output logic                   led_new
);

  localparam int NIB   = DATA_W / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CNT_W = $clog2(DWELL);
  localparam int SUM_W = IDX_W + 1;
  localparam int NSEG  = NUM_WIN + 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [4:0]       NIB_CNT  = 5'(NIB);

  logic [DATA_W-1:0]    char_store_q, char_store_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     dwell_cnt_q, dwell_cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic                 led_new_q, led_new_d;
  logic [7*NUM_WIN-1:0] disp_data_q, disp_data_d;
  logic [6:0]           disp_idx_q, disp_idx_d;

  logic                 mode_chg;
  logic                 tick;
  logic                 advance;
  logic [IDX_W-1:0]     idx_inc;
  logic [SUM_W-1:0]     win_sum [NUM_WIN];
  logic [4*NSEG-1:0]    seg_in;
  logic [7*NSEG-1:0]    seg_out;

  // Capture, dwell timing and index sequencing
  always_comb begin
    mode_d       = mode;
    mode_chg     = (mode != mode_q);
    char_store_d = char_valid ? char : char_store_q;

    tick        = (dwell_cnt_q == CNT_LAST) && !mode_chg;
    dwell_cnt_d = (mode_chg || dwell_cnt_q == CNT_LAST) ? '0 : dwell_cnt_q + CNT_W'(1);

    idx_inc = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    advance = 1'b0;
    idx_d   = idx_q;
    case (mode)
      MODE_STEP: advance = tick && char_valid;
      MODE_AUTO: advance = tick;
      MODE_DIRECT: begin
        if ({1'b0, sel_idx} < NIB_CNT) begin
          idx_d = sel_idx[IDX_W-1:0];
        end
      end
      default: ;
    endcase
    if (advance) begin
      idx_d = idx_inc;
    end

    // A capture in the same cycle as the sweep wrap keeps the flag set
    led_new_d = led_new_q;
    if (advance && idx_q == IDX_LAST) begin
      led_new_d = 1'b0;
    end
    if (char_valid) begin
      led_new_d = 1'b1;
    end
  end

  // Window nibble selection; modulo NIB by a single conditional subtract
  always_comb begin
    seg_in = '0;
    for (int w = 0; w < NUM_WIN; w++) begin
      win_sum[w] = SUM_W'(idx_q) + SUM_W'(w);
      if (win_sum[w] >= SUM_W'(NIB)) begin
        win_sum[w] = win_sum[w] - SUM_W'(NIB);
      end
      for (int n = 0; n < NIB; n++) begin
        if (win_sum[w] == SUM_W'(n)) begin
          seg_in[4*w +: 4] = char_store_q[4*n +: 4];
        end
      end
    end
    seg_in[4*NUM_WIN +: IDX_W] = idx_q;
  end

  // Slots 0..NUM_WIN-1 are data digits, slot NUM_WIN is the index digit
  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    seg7 u_seg7 (
      .bcd  (seg_in[4*g +: 4]),
      .leds (seg_out[7*g +: 7])
    );
  end

  always_comb begin
    disp_data_d = blank ? {NUM_WIN{SEG_BLANK}} : seg_out[7*NUM_WIN-1:0];
    disp_idx_d  = blank ? SEG_BLANK : seg_out[7*NUM_WIN +: 7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_store_q <= '0;
      idx_q        <= '0;
      dwell_cnt_q  <= '0;
      mode_q       <= MODE_STEP;
      led_new_q    <= 1'b0;
      disp_data_q  <= {NUM_WIN{SEG_BLANK}};
      disp_idx_q   <= SEG_BLANK;
    end else begin
      char_store_q <= char_store_d;
      idx_q        <= idx_d;
      dwell_cnt_q  <= dwell_cnt_d;
      mode_q       <= mode_d;
      led_new_q    <= led_new_d;
      disp_data_q  <= disp_data_d;
      disp_idx_q   <= disp_idx_d;
    end
  end

  assign disp_data = disp_data_q;
  assign disp_idx  = disp_idx_q;
  assign led_valid = char_valid;
  assign led_new   = led_new_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_word_scanner.sv
`default_nettype none
// ============================================================================
//  Module : tb_hex_word_scanner
//  Brief  : Directed self-checking bench: 32-bit/2-window and 24-bit/3-window
//  Rev    : 1.0  initial release
// ============================================================================
module tb_hex_word_scanner;

  logic        clk;
  logic        rst_n;
  logic [31:0] char;
  logic        char_valid;
  logic [1:0]  mode;
  logic [3:0]  sel_idx;
  logic        blank;

  logic [13:0] disp_data_a;
  logic [6:0]  disp_idx_a;
  logic        led_valid_a;
  logic        led_new_a;

  logic [20:0] disp_data_b;
  logic [6:0]  disp_idx_b;
  logic        led_valid_b;
  logic        led_new_b;

  int checks   = 0;
  int failures = 0;

  hex_word_scanner #(.DATA_W(32), .NUM_WIN(2), .DWELL(8)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .char       (char),
    .char_valid (char_valid),
    .mode       (mode),
    .sel_idx    (sel_idx),
    .blank      (blank),
    .disp_data  (disp_data_a),
    .disp_idx   (disp_idx_a),
    .led_valid  (led_valid_a),
    .led_new    (led_new_a)
  );

  hex_word_scanner #(.DATA_W(24), .NUM_WIN(3), .DWELL(8)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .char       (char[23:0]),
    .char_valid (char_valid),
    .mode       (mode),
    .sel_idx    (sel_idx),
    .blank      (blank),
    .disp_data  (disp_data_b),
    .disp_idx   (disp_idx_b),
    .led_valid  (led_valid_b),
    .led_new    (led_new_b)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b1;
    char       = '0;
    char_valid = 1'b0;
    mode       = 2'b00;
    sel_idx    = 4'd0;
    blank      = 1'b0;

    #3 rst_n = 1'b0;
    #1;
    chk("rst_data_a", 32'(disp_data_a), 32'h3FFF);
    chk("rst_idx_a",  32'(disp_idx_a),  32'h7F);
    chk("rst_new_a",  32'(led_new_a),   32'h0);
    chk("rst_data_b", 32'(disp_data_b), 32'h1FFFFF);
    chk("rst_new_b",  32'(led_new_b),   32'h0);

    step(1);
    rst_n = 1'b1;
    step(1);
    chk("idle_data", 32'(disp_data_a), 32'({seg(4'h0), seg(4'h0)}));
    chk("idle_idx",  32'(disp_idx_a),  32'(seg(4'h0)));
    chk("idle_lv",   32'(led_valid_a), 32'h0);

    // STEP mode, valid held high
    char       = 32'h89AB_CDEF;
    char_valid = 1'b1;
    mode       = 2'b00;
    #1;
    chk("led_valid", 32'(led_valid_a), 32'h1);
    step(1);
    chk("cap_new",   32'(led_new_a),   32'h1);
    step(1);
    chk("step0_data", 32'(disp_data_a), 32'({seg(4'hE), seg(4'hF)}));
    chk("step0_idx",  32'(disp_idx_a),  32'(seg(4'h0)));
    step(5);
    chk("step_lag_idx", 32'(disp_idx_a), 32'(seg(4'h0)));
    step(1);
    chk("step1_idx",  32'(disp_idx_a),  32'(seg(4'h1)));
    chk("step1_data", 32'(disp_data_a), 32'({seg(4'hD), seg(4'hE)}));
    step(48);
    chk("step7_idx",  32'(disp_idx_a),  32'(seg(4'h7)));
    chk("step7_data", 32'(disp_data_a), 32'({seg(4'hF), seg(4'h8)}));
    step(8);
    chk("stepwrap_idx",  32'(disp_idx_a),  32'(seg(4'h0)));
    chk("stepwrap_data", 32'(disp_data_a), 32'({seg(4'hE), seg(4'hF)}));
    chk("stepwrap_new",  32'(led_new_a),   32'h1);

    // AUTO mode, no captures: mode change restarts the dwell
    mode       = 2'b01;
    char_valid = 1'b0;
    step(64);
    chk("auto7_idx", 32'(disp_idx_a), 32'(seg(4'h7)));
    chk("auto7_new", 32'(led_new_a),  32'h1);
    step(1);
    chk("autowrap_new", 32'(led_new_a), 32'h0);
    step(63);
    char       = 32'h1234_5678;
    char_valid = 1'b1;
    step(1);
    chk("wrapcap_new", 32'(led_new_a), 32'h1);
    char_valid = 1'b0;
    step(1);
    chk("wrapcap_data", 32'(disp_data_a), 32'({seg(4'h7), seg(4'h8)}));
    chk("wrapcap_idx",  32'(disp_idx_a),  32'(seg(4'h0)));
    chk("wrapcap_new2", 32'(led_new_a),   32'h1);

    // DIRECT selection, out-of-range ignored, then HOLD
    mode    = 2'b11;
    sel_idx = 4'd5;
    step(2);
    chk("dir5_idx",  32'(disp_idx_a),  32'(seg(4'h5)));
    chk("dir5_data", 32'(disp_data_a), 32'({seg(4'h2), seg(4'h3)}));
    sel_idx = 4'd12;
    step(2);
    chk("dir12_idx", 32'(disp_idx_a), 32'(seg(4'h5)));
    chk("dir_new",   32'(led_new_a),  32'h1);
    sel_idx = 4'd2;
    step(1);
    mode    = 2'b10;
    sel_idx = 4'd7;
    step(20);
    chk("hold_idx",  32'(disp_idx_a),  32'(seg(4'h2)));
    chk("hold_data", 32'(disp_data_a), 32'({seg(4'h5), seg(4'h6)}));

    // One-cycle blank
    blank = 1'b1;
    step(1);
    chk("blank_data", 32'(disp_data_a), 32'h3FFF);
    chk("blank_idx",  32'(disp_idx_a),  32'h7F);
    blank = 1'b0;
    step(1);
    chk("unblank_idx",  32'(disp_idx_a),  32'(seg(4'h2)));
    chk("unblank_data", 32'(disp_data_a), 32'({seg(4'h5), seg(4'h6)}));

    // Asynchronous reset mid-dwell
    mode = 2'b01;
    step(3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_data_a", 32'(disp_data_a), 32'h3FFF);
    chk("midrst_idx_a",  32'(disp_idx_a),  32'h7F);
    chk("midrst_new_a",  32'(led_new_a),   32'h0);
    chk("midrst_data_b", 32'(disp_data_b), 32'h1FFFFF);

    // 24-bit / 3-window instance: non-power-of-two wrap and dwell restart
    mode       = 2'b11;
    sel_idx    = 4'd5;
    char       = 32'h0065_4321;
    char_valid = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("b_idx5_data", 32'(disp_data_b), 32'({seg(4'h2), seg(4'h1), seg(4'h6)}));
    chk("b_idx5_idx",  32'(disp_idx_b),  32'(seg(4'h5)));
    chk("b_new",       32'(led_new_b),   32'h1);
    char_valid = 1'b0;
    mode       = 2'b00;
    step(4);
    mode = 2'b01;
    step(9);
    chk("b_restart_idx", 32'(disp_idx_b), 32'(seg(4'h5)));
    chk("b_wrap_new",    32'(led_new_b),  32'h0);
    step(1);
    chk("b_wrap_idx",  32'(disp_idx_b),  32'(seg(4'h0)));
    chk("b_wrap_data", 32'(disp_data_b), 32'({seg(4'h3), seg(4'h2), seg(4'h1)}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
